// File: rtl/matmul_pool_engine_if.sv
// Start handshake plus A/B read ports and C write port of matmul_pool_engine.
interface matmul_pool_engine_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 10
);
    logic            kick_start;
    logic            ready;
    logic            done;
    logic            mem_read_en_A;
    logic [AW-1:0]   mem_addr_A;
    logic [N*DW-1:0] mem_data_A;
    logic            mem_read_en_B;
    logic [AW-1:0]   mem_addr_B;
    logic [N*DW-1:0] mem_data_B;
    logic            mem_write_en_C;
    logic [AW-1:0]   mem_addr_C;
    logic [N*DW-1:0] mem_data_C;

    modport master (
        input  kick_start, mem_data_A, mem_data_B,
        output ready, done,
        output mem_read_en_A, mem_addr_A,
        output mem_read_en_B, mem_addr_B,
        output mem_write_en_C, mem_addr_C, mem_data_C
    );

    modport slave (
        output kick_start, mem_data_A, mem_data_B,
        input  ready, done,
        input  mem_read_en_A, mem_addr_A,
        input  mem_read_en_B, mem_addr_B,
        input  mem_write_en_C, mem_addr_C, mem_data_C
    );
endinterface

// File: rtl/matmul_pool_engine.sv
// NxN unsigned saturating matrix multiply with optional 2x2 average pooling.
// Define MATMUL_POOL_EN to build the pooling stage; otherwise raw rows are written.
module matmul_pool_engine #(
    parameter int unsigned   N      = 4,
    parameter int unsigned   DW     = 8,
    parameter int unsigned   AW     = 10,
    parameter logic [AW-1:0] BASE_A = AW'('h000),
    parameter logic [AW-1:0] BASE_B = AW'('h100),
    parameter logic [AW-1:0] BASE_C = AW'('h200)
) (
    input logic                  clk,
    input logic                  rstn,
    matmul_pool_engine_if.master bus
);
    localparam int unsigned ACC_W = 2*DW + $clog2(N);
    localparam int unsigned CW    = $clog2(N);
    localparam int unsigned PSW   = DW + 2;
`ifdef MATMUL_POOL_EN
    localparam int unsigned HN    = N / 2;
    localparam int unsigned HW    = (HN > 1) ? $clog2(HN) : 1;
    localparam int unsigned NW    = HN;
`else
    localparam int unsigned NW    = N;
`endif
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CAP, S_MAC, S_STORE,
`ifdef MATMUL_POOL_EN
        S_POOL,
`endif
        S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, row_d, col_q, col_d, k_q, k_d, w_q, w_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [N*DW-1:0]   a_row_q, a_row_d, b_col_q, b_col_d;
    logic [DW-1:0]     res_q [N][N];
    logic [DW-1:0]     res_d [N][N];
    logic [DW-1:0]     a_el_c, b_el_c, sat_c;

    logic              ready_q, ready_d, done_q, done_d;
    logic              rd_a_q, rd_a_d, rd_b_q, rd_b_d, wr_c_q, wr_c_d;
    logic [AW-1:0]     addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [N*DW-1:0]   data_c_q, data_c_d;

`ifdef MATMUL_POOL_EN
    logic [DW-1:0]     pool_q [HN][HN];
    logic [DW-1:0]     pool_d [HN][HN];
    logic [HW-1:0]     pr_q, pr_d, pc_q, pc_d;
    logic [CW-1:0]     r0_c, r1_c, c0_c, c1_c;
    logic [PSW-1:0]    psum_c;
`endif

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        w_d      = w_q;
        acc_d    = acc_q;
        a_row_d  = a_row_q;
        b_col_d  = b_col_q;
        res_d    = res_q;
        a_el_c   = a_row_q[DW*int'(k_q) +: DW];
        b_el_c   = b_col_q[DW*int'(k_q) +: DW];
        sat_c    = (acc_q > SAT_MAX) ? {DW{1'b1}} : acc_q[DW-1:0];
`ifdef MATMUL_POOL_EN
        pool_d   = pool_q;
        pr_d     = pr_q;
        pc_d     = pc_q;
        r0_c     = CW'({pr_q, 1'b0});
        r1_c     = r0_c + CW'(1);
        c0_c     = CW'({pc_q, 1'b0});
        c1_c     = c0_c + CW'(1);
        psum_c   = PSW'(res_q[r0_c][c0_c]) + PSW'(res_q[r0_c][c1_c])
                 + PSW'(res_q[r1_c][c0_c]) + PSW'(res_q[r1_c][c1_c]);
`endif

        case (state_q)
            S_IDLE:  if (bus.kick_start) state_d = S_RD_A;
            S_RD_A:  state_d = S_RD_B;
            S_RD_B: begin
                a_row_d = bus.mem_data_A;
                state_d = S_CAP;
            end
            S_CAP: begin
                b_col_d = bus.mem_data_B;
                acc_d   = '0;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(a_el_c) * ACC_W'(b_el_c);
                if (k_q == CW'(N-1)) state_d = S_STORE;
                else                 k_d     = k_q + CW'(1);
            end
            S_STORE: begin
                res_d[row_q][col_q] = sat_c;
                state_d = S_RD_A;
                if (col_q == CW'(N-1)) begin
                    col_d = '0;
                    if (row_q == CW'(N-1)) begin
                        row_d = '0;
`ifdef MATMUL_POOL_EN
                        state_d = S_POOL;
`else
                        state_d = S_WRITE;
`endif
                    end else begin
                        row_d = row_q + CW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
`ifdef MATMUL_POOL_EN
            S_POOL: begin
                pool_d[pr_q][pc_q] = DW'(psum_c >> 2);
                if (pc_q == HW'(HN-1)) begin
                    pc_d = '0;
                    if (pr_q == HW'(HN-1)) begin
                        pr_d    = '0;
                        state_d = S_WRITE;
                    end else begin
                        pr_d = pr_q + HW'(1);
                    end
                end else begin
                    pc_d = pc_q + HW'(1);
                end
            end
`endif
            S_WRITE: begin
                if (w_q == CW'(NW-1)) begin
                    w_d     = '0;
                    state_d = S_DONE;
                end else begin
                    w_d = w_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state presents
        ready_d  = (state_d == S_IDLE);
        done_d   = (state_d == S_DONE);
        rd_a_d   = (state_d == S_RD_A);
        rd_b_d   = (state_d == S_RD_B);
        wr_c_d   = (state_d == S_WRITE);
        addr_a_d = BASE_A + AW'(row_d);
        addr_b_d = BASE_B + AW'(col_d);
        addr_c_d = BASE_C + AW'(w_d);
        data_c_d = '0;
        if (wr_c_d) begin
`ifdef MATMUL_POOL_EN
            for (int j = 0; j < int'(HN); j++)
                data_c_d[j*DW +: DW] = pool_d[HW'(w_d)][j];
`else
            for (int j = 0; j < int'(N); j++)
                data_c_d[j*DW +: DW] = res_d[w_d][j];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            w_q      <= '0;
            acc_q    <= '0;
            a_row_q  <= '0;
            b_col_q  <= '0;
            res_q    <= '{default: '0};
`ifdef MATMUL_POOL_EN
            pool_q   <= '{default: '0};
            pr_q     <= '0;
            pc_q     <= '0;
`endif
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            wr_c_q   <= 1'b0;
            addr_a_q <= BASE_A;
            addr_b_q <= BASE_B;
            addr_c_q <= BASE_C;
            data_c_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            w_q      <= w_d;
            acc_q    <= acc_d;
            a_row_q  <= a_row_d;
            b_col_q  <= b_col_d;
            res_q    <= res_d;
`ifdef MATMUL_POOL_EN
            pool_q   <= pool_d;
            pr_q     <= pr_d;
            pc_q     <= pc_d;
`endif
            ready_q  <= ready_d;
            done_q   <= done_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            wr_c_q   <= wr_c_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            data_c_q <= data_c_d;
        end
    end

    assign bus.ready          = ready_q;
    assign bus.done           = done_q;
    assign bus.mem_read_en_A  = rd_a_q;
    assign bus.mem_addr_A     = addr_a_q;
    assign bus.mem_read_en_B  = rd_b_q;
    assign bus.mem_addr_B     = addr_b_q;
    assign bus.mem_write_en_C = wr_c_q;
    assign bus.mem_addr_C     = addr_c_q;
    assign bus.mem_data_C     = data_c_q;
endmodule

// File: tb/tb_matmul_pool_engine.sv
// Randomised self-checking bench for matmul_pool_engine against a plain-arithmetic matrix model.
module tb_matmul_pool_engine;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam logic [AW-1:0] BASE_A = 10'h000;
    localparam logic [AW-1:0] BASE_B = 10'h100;
    localparam logic [AW-1:0] BASE_C = 10'h200;
    localparam int HN = N / 2;
`ifdef MATMUL_POOL_EN
    localparam int NW = HN;
    localparam int EXP_CYC = N*N*(N+4) + HN*HN + HN + 1;
`else
    localparam int NW = N;
    localparam int EXP_CYC = N*N*(N+4) + N + 1;
`endif

    logic clk, rstn;
    int   checks, errors;
    int   ma [N][N];   // A[r][k]
    int   mb [N][N];   // B[k][c]
    logic [N*DW-1:0] exp_q [$];
    logic [AW-1:0]   wr_addr_q [$];
    logic [N*DW-1:0] wr_data_q [$];
    int   overlap_err, addr_err, done_cnt;

    matmul_pool_engine_if #(.N(N), .DW(DW), .AW(AW)) bus ();
    matmul_pool_engine #(.N(N), .DW(DW), .AW(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] row_word(input int r);
        logic [N*DW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(ma[r][k]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] col_word(input int c);
        logic [N*DW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(mb[k][c]);
        return v;
    endfunction

    // One-cycle-latency memories plus a bus monitor
    always @(posedge clk) begin
        if (bus.mem_read_en_A) bus.mem_data_A <= row_word(int'(bus.mem_addr_A - BASE_A));
        if (bus.mem_read_en_B) bus.mem_data_B <= col_word(int'(bus.mem_addr_B - BASE_B));
        if (bus.mem_read_en_A && bus.mem_read_en_B) overlap_err++;
        if (bus.mem_read_en_A && (bus.mem_addr_A < BASE_A || bus.mem_addr_A >= BASE_A + AW'(N))) addr_err++;
        if (bus.mem_read_en_B && (bus.mem_addr_B < BASE_B || bus.mem_addr_B >= BASE_B + AW'(N))) addr_err++;
        if (bus.mem_write_en_C) begin
            wr_addr_q.push_back(bus.mem_addr_C);
            wr_data_q.push_back(bus.mem_data_C);
        end
        if (bus.done) done_cnt++;
    end

    task automatic build_expected();
        int c [N][N];
        logic [N*DW-1:0] w;
        exp_q.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                c[i][j] = (s > 255) ? 255 : s;
            end
`ifdef MATMUL_POOL_EN
        for (int i = 0; i < HN; i++) begin
            w = '0;
            for (int j = 0; j < HN; j++)
                w[j*DW +: DW] = DW'((c[2*i][2*j] + c[2*i][2*j+1] + c[2*i+1][2*j] + c[2*i+1][2*j+1]) / 4);
            exp_q.push_back(w);
        end
`else
        for (int i = 0; i < N; i++) begin
            w = '0;
            for (int j = 0; j < N; j++) w[j*DW +: DW] = DW'(c[i][j]);
            exp_q.push_back(w);
        end
`endif
    endtask

    task automatic clear_monitor();
        wr_addr_q.delete();
        wr_data_q.delete();
        overlap_err = 0;
        addr_err    = 0;
        done_cnt    = 0;
    endtask

    task automatic fill(input int amax, input int bmax);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = $urandom_range(amax, 0);
                mb[i][j] = $urandom_range(bmax, 0);
            end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_check(input string name);
        int cyc;
        build_expected();
        clear_monitor();
        @(negedge clk);
        if (bus.ready !== 1'b1) begin
            errors++; $display("FAIL %s ready-before-kick: got %b want 1", name, bus.ready);
        end
        checks++;
        bus.kick_start = 1'b1;
        @(posedge clk); #1;
        bus.kick_start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== EXP_CYC) begin
            errors++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, EXP_CYC);
        end
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++; $display("FAIL %s ready-at-done: got %b want 0", name, bus.ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL %s after-done: done %b ready %b want 0/1", name, bus.done, bus.ready);
        end
        checks++;
        if (wr_data_q.size() !== NW) begin
            errors++; $display("FAIL %s write-count: got %0d want %0d", name, wr_data_q.size(), NW);
        end
        for (int i = 0; i < NW && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== BASE_C + AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d: got %h@%h want %h@%h", name, i, wr_data_q[i], wr_addr_q[i],
                         exp_q[i], BASE_C + AW'(i));
            end
        end
        checks++;
        if (overlap_err !== 0 || addr_err !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL %s bus-rules: overlap %0d badaddr %0d dones %0d want 0/0/1", name, overlap_err, addr_err, done_cnt);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.kick_start = 1'b0;
        #12;
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.mem_read_en_A !== 1'b0 ||
            bus.mem_read_en_B !== 1'b0 || bus.mem_write_en_C !== 1'b0) begin
            errors++;
            $display("FAIL reset-ctrl: rdy %b done %b enA %b enB %b enC %b want 1/0/0/0/0", bus.ready, bus.done,
                     bus.mem_read_en_A, bus.mem_read_en_B, bus.mem_write_en_C);
        end
        checks++;
        if (bus.mem_addr_A !== BASE_A || bus.mem_addr_B !== BASE_B || bus.mem_addr_C !== BASE_C || bus.mem_data_C !== '0) begin
            errors++;
            $display("FAIL reset-bus: A %h B %h C %h D %h want %h %h %h 0", bus.mem_addr_A, bus.mem_addr_B,
                     bus.mem_addr_C, bus.mem_data_C, BASE_A, BASE_B, BASE_C);
        end
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_read_en_A !== 1'b0) begin
            errors++; $display("FAIL idle-hold: ready %b enA %b want 1/0", bus.ready, bus.mem_read_en_A);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 1; mb[i][j] = 1; end
        run_check("ones");
`ifdef MATMUL_POOL_EN
        checks++;
        if (wr_data_q[0] !== 32'h0000_0404 || wr_data_q[1] !== 32'h0000_0404) begin
            errors++; $display("FAIL ones-const: got %h %h want 00000404", wr_data_q[0], wr_data_q[1]);
        end
`endif
    endtask

    task automatic test_saturate();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 255; mb[i][j] = 255; end
        run_check("saturate");
`ifdef MATMUL_POOL_EN
        checks++;
        if (wr_data_q[1] !== 32'h0000_FFFF) begin
            errors++; $display("FAIL sat-const: got %h want 0000ffff", wr_data_q[1]);
        end
`endif
    endtask

    task automatic test_identity();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            ma[i][j] = (i == j) ? 1 : 0;
            mb[i][j] = 4*i + j;
        end
        run_check("identity");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            case (t % 3)
                0: fill(15, 15);
                1: fill(20, 12);
                default: fill(255, 255);
            endcase
            run_check($sformatf("random%0d", t));
        end
    endtask

    task automatic test_kick_held();
        int cyc;
        fill(15, 15);
        build_expected();
        clear_monitor();
        @(negedge clk);
        bus.kick_start = 1'b1;
        wait_done(cyc);
        checks++;
        if (cyc !== EXP_CYC || wr_data_q.size() !== NW) begin
            errors++; $display("FAIL held-run: cycles %0d writes %0d want %0d/%0d", cyc, wr_data_q.size(), EXP_CYC, NW);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || done_cnt !== 1) begin
            errors++; $display("FAIL held-idle: ready %b dones %0d want 1/1", bus.ready, done_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.mem_read_en_A !== 1'b1) begin
            errors++; $display("FAIL held-restart: ready %b enA %b want 0/1", bus.ready, bus.mem_read_en_A);
        end
        bus.kick_start = 1'b0;
        wait_done(cyc);
        @(posedge clk); #1;
        checks++;
        if (done_cnt !== 2 || wr_data_q.size() !== 2*NW || bus.ready !== 1'b1) begin
            errors++; $display("FAIL held-second: dones %0d writes %0d ready %b want 2/%0d/1", done_cnt, wr_data_q.size(), bus.ready, 2*NW);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 1; mb[i][j] = 1; end
        clear_monitor();
        @(negedge clk) bus.kick_start = 1'b1;
        @(posedge clk); #1;
        bus.kick_start = 1'b0;
        n = 0;
        while (!(bus.mem_read_en_B === 1'b1 && bus.mem_addr_B === BASE_B + 10'd2 && bus.mem_addr_A === BASE_A + 10'd1) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++; $display("FAIL abort-reach: element (1,2) read not seen within %0d cycles", n);
        end
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_read_en_A !== 1'b0 || bus.mem_read_en_B !== 1'b0 || bus.mem_write_en_C !== 1'b0) begin
            errors++;
            $display("FAIL abort-state: ready %b enA %b enB %b enC %b want 1/0/0/0", bus.ready,
                     bus.mem_read_en_A, bus.mem_read_en_B, bus.mem_write_en_C);
        end
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_data_q.size() !== 0 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL abort-writes: got %0d writes ready %b want 0/1", wr_data_q.size(), bus.ready);
        end
        test_ones();
    endtask

`ifndef MATMUL_POOL_EN
    task automatic test_scale();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            ma[i][j] = (i == j) ? 2 : 0;
            mb[i][j] = 3;
        end
        run_check("scale");
        checks++;
        if (wr_data_q[0] !== 32'h0606_0606 || wr_data_q[3] !== 32'h0606_0606) begin
            errors++; $display("FAIL scale-const: got %h %h want 06060606", wr_data_q[0], wr_data_q[3]);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        bus.kick_start = 1'b0;
        bus.mem_data_A = '0;
        bus.mem_data_B = '0;
        clear_monitor();
        test_reset();
        test_ones();
        test_saturate();
        test_identity();
        test_random();
        test_kick_held();
        test_reset_abort();
`ifndef MATMUL_POOL_EN
        test_scale();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
